// File: rtl/expmob_iter.sv
// Iterative GF(2) Moebius (ANF) transform engine: subset or superset transform of
// an N-bit vector, STAGES_PER_CYCLE butterfly stages per clock, valid/ready on both sides.
module expmob_iter #(
  parameter int N                = 32,
  parameter int LOG2_N           = 5,
  parameter int STAGES_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:N-1] in_data,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:N-1] out_data,
  output logic         busy
);

  localparam int SPC = STAGES_PER_CYCLE;
  localparam int CW  = $clog2(LOG2_N + 1);

  if (N != (1 << LOG2_N)) begin : g_bad_n
    $error("expmob_iter: N must equal 1 << LOG2_N");
  end
  if ((SPC < 1) || (SPC > LOG2_N) || ((LOG2_N % SPC) != 0)) begin : g_bad_spc
    $error("expmob_iter: STAGES_PER_CYCLE must divide LOG2_N");
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; the producer holds data while valid && !ready, the engine holds out_data
  // while out_valid && !out_ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [0:N-1]  vec;
  logic [0:N-1]  run_vec;
  logic          mode;
  logic [CW-1:0] cnt;

  // Every stage is elaborated; only stages cnt..cnt+SPC-1 are enabled, chained in
  // ascending order so the result matches applying them one after another.
  always_comb begin
    run_vec = vec;
    for (int s = 0; s < LOG2_N; s++) begin
      if ((s >= int'(cnt)) && (s < int'(cnt) + SPC)) begin
        for (int p = 0; p < N / 2; p++) begin
          if (mode) begin
            run_vec[(p / (N >> (s + 1))) * (N >> s) + (p % (N >> (s + 1)))] =
              run_vec[(p / (N >> (s + 1))) * (N >> s) + (p % (N >> (s + 1)))] ^
              run_vec[(p / (N >> (s + 1))) * (N >> s) + (p % (N >> (s + 1))) + (N >> (s + 1))];
          end else begin
            run_vec[(p / (N >> (s + 1))) * (N >> s) + (p % (N >> (s + 1))) + (N >> (s + 1))] =
              run_vec[(p / (N >> (s + 1))) * (N >> s) + (p % (N >> (s + 1)))] ^
              run_vec[(p / (N >> (s + 1))) * (N >> s) + (p % (N >> (s + 1))) + (N >> (s + 1))];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (int'(cnt) + SPC == LOG2_N) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Mode is captured only at accept, so in_mode activity during RUN is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec  <= '0;
      mode <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            vec  <= in_data;
            mode <= in_mode;
            cnt  <= '0;
          end
        end
        RUN: begin
          vec <= run_vec;
          cnt <= cnt + CW'(SPC);
        end
        default: ;
      endcase
    end
  end

  assign out_data = vec;

endmodule

// File: tb/tb_expmob_iter.sv
// Bench for expmob_iter: three instances (N=8/SPC=1, N=32/SPC=1, N=32/SPC=5) checked
// against a subset/superset-sum reference model through one scoreboard.
module tb_expmob_iter;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  logic        in_valid [3];
  logic        in_mode  [3];
  logic        out_ready[3];
  logic        in_ready [3];
  logic        out_valid[3];
  logic        busy     [3];
  logic [0:31] in_data  [3];
  logic [0:31] out_data [3];
  logic [0:7]  od8;

  int tests = 0;
  int fails = 0;

  int act = 0;
  logic cur_iv, cur_ir, cur_im, cur_ov, cur_or, cur_busy;
  logic [0:31] cur_id, cur_od;

  logic [31:0] exp_q[$];
  int          acc_q[$];
  logic        prev_ov  = 1'b0;
  logic        acc_flag = 1'b0;
  logic        btb_chk  = 1'b0;
  logic        have_acc = 1'b0;
  int          last_acc = 0;

  expmob_iter #(.N(8), .LOG2_N(3), .STAGES_PER_CYCLE(1)) u_n8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0][0:7]), .in_mode(in_mode[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(od8), .busy(busy[0])
  );
  assign out_data[0] = {od8, 24'b0};

  expmob_iter #(.N(32), .LOG2_N(5), .STAGES_PER_CYCLE(1)) u_n32_s1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_mode(in_mode[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
  );

  expmob_iter #(.N(32), .LOG2_N(5), .STAGES_PER_CYCLE(5)) u_n32_s5 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]), .in_mode(in_mode[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2])
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    cur_iv   = in_valid[act];
    cur_ir   = in_ready[act];
    cur_im   = in_mode[act];
    cur_id   = in_data[act];
    cur_ov   = out_valid[act];
    cur_or   = out_ready[act];
    cur_od   = out_data[act];
    cur_busy = busy[act];
  end

  function automatic int lane_n(input int l);
    return (l == 0) ? 8 : 32;
  endfunction

  function automatic int lane_c(input int l);
    return (l == 0) ? 3 : ((l == 1) ? 5 : 1);
  endfunction

  // Reference: y[j] = XOR of x[i] over i subset of j (mode 0) or i superset of j (mode 1).
  function automatic logic [0:31] mob(input logic [0:31] x, input int n, input logic m);
    logic [0:31] y;
    logic        b;
    y = '0;
    for (int j = 0; j < n; j++) begin
      b = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (m == 1'b0 ? ((i & j) == i) : ((i & j) == j)) b = b ^ x[i];
      end
      y[j] = b;
    end
    return y;
  endfunction

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d, lane %0d)", name, a, e, cyc, act);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      prev_ov = 1'b0;
    end else begin
      chk("busy_vs_ready", {31'b0, cur_busy}, {31'b0, !cur_ir});
      if (cur_iv && cur_ir) begin
        exp_q.push_back(mob(cur_id, lane_n(act), cur_im));
        acc_q.push_back(cyc);
        if (btb_chk && have_acc) chk("issue_interval", cyc - last_acc, lane_c(act) + 2);
        last_acc = cyc;
        have_acc = 1'b1;
        acc_flag = 1'b1;
      end
      if (cur_ov) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {31'b0, cur_ov}, 32'd0);
        end else begin
          chk("out_data", cur_od, exp_q[0]);
          if (!prev_ov) chk("latency", cyc - acc_q[0], lane_c(act) + 1);
          if (cur_or) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      prev_ov = cur_ov;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [0:31] d, input logic m);
    bit ok = 1'b0;
    in_data[act]  = d;
    in_mode[act]  = m;
    in_valid[act] = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (cur_ir) ok = 1'b1;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid[act] = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (cur_ov) ok = 1'b1;
    end
    if (!ok) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic recv(output logic [0:31] got);
    out_ready[act] = 1'b1;
    wait_valid();
    got = cur_od;
    @(posedge clk);
    #1 out_ready[act] = 1'b0;
  endtask

  task automatic back_to_back(input int cycles);
    btb_chk  = 1'b1;
    have_acc = 1'b0;
    acc_flag = 1'b0;
    in_data[act]   = $urandom;
    in_mode[act]   = 1'($urandom_range(0, 1));
    in_valid[act]  = 1'b1;
    out_ready[act] = 1'b1;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (acc_flag) begin
        acc_flag = 1'b0;
        in_data[act] = $urandom;
      end
      in_mode[act] = 1'($urandom_range(0, 1));
    end
    in_valid[act] = 1'b0;
    repeat (lane_c(act) + 4) @(posedge clk);
    #1 out_ready[act] = 1'b0;
    btb_chk = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [0:31] got;
    logic [0:31] d;
    rst = 1'b1;
    for (int l = 0; l < 3; l++) begin
      in_valid[l] = 1'b0; in_mode[l] = 1'b0; out_ready[l] = 1'b0; in_data[l] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int l = 0; l < 3; l++) begin
      chk("rst_in_ready",  {31'b0, in_ready[l]},  32'd1);
      chk("rst_out_valid", {31'b0, out_valid[l]}, 32'd0);
      chk("rst_busy",      {31'b0, busy[l]},      32'd0);
      chk("rst_out_data",  out_data[l],           32'd0);
    end
    rst = 1'b0;

    // Literal pins on the reference model itself.
    chk("model_pin_sub", mob({8'b1100_0000, 24'b0}, 8, 1'b0), {8'b1010_1010, 24'b0});
    chk("model_pin_sup", mob({8'b0000_0001, 24'b0}, 8, 1'b1), {8'b1111_1111, 24'b0});
    chk("model_pin_32",  mob(32'h8000_0000, 32, 1'b0), 32'hFFFF_FFFF);

    // N=8 directed cases.
    act = 0;
    @(posedge clk); #1;
    send({8'b1100_0000, 24'b0}, 1'b0);
    recv(got);
    chk("basic_subset", got, {8'b1010_1010, 24'b0});
    send({8'b0000_0001, 24'b0}, 1'b1);
    recv(got);
    chk("dual_ones", got, {8'b1111_1111, 24'b0});
    send(got, 1'b1);
    recv(got);
    chk("dual_involution", got, {8'b0000_0001, 24'b0});

    // Backpressure in DONE.
    send({8'b1000_0000, 24'b0}, 1'b0);
    wait_valid();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid",    {31'b0, cur_ov}, 32'd1);
      chk("bp_in_ready", {31'b0, cur_ir}, 32'd0);
      chk("bp_data",     cur_od, {8'b1111_1111, 24'b0});
    end
    @(posedge clk);
    #1 out_ready[act] = 1'b1;
    @(posedge clk);
    #1 out_ready[act] = 1'b0;
    @(negedge clk);
    chk("bp_release_ready", {31'b0, cur_ir}, 32'd1);
    chk("bp_release_valid", {31'b0, cur_ov}, 32'd0);

    // Random equivalence on both N=32 instances, with occasional consumer stalls.
    for (int l = 1; l < 3; l++) begin
      act = l;
      @(posedge clk); #1;
      for (int t = 0; t < 1000; t++) begin
        d = $urandom;
        send(d, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 recv(got);
      end
    end

    // Reset on the 2nd RUN cycle discards the transaction.
    act = 1;
    @(posedge clk); #1;
    send($urandom, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrun_in_ready",  {31'b0, cur_ir},   32'd1);
    chk("midrun_out_valid", {31'b0, cur_ov},   32'd0);
    chk("midrun_busy",      {31'b0, cur_busy}, 32'd0);
    chk("midrun_out_data",  cur_od,            32'd0);
    send(32'h8000_0000, 1'b0);
    recv(got);
    chk("after_reset_txn", got, 32'hFFFF_FFFF);

    // Back-to-back issue with in_mode toggling during RUN.
    for (int l = 1; l < 3; l++) begin
      act = l;
      @(posedge clk); #1;
      back_to_back(70);
    end

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
